// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared encodings and helpers for ram_be_sync
package ram_pkg;

  localparam int RM_WRITE_FIRST = 0;
  localparam int RM_READ_FIRST  = 1;
  localparam int RM_NO_CHANGE   = 2;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } state_t;

  function automatic int bytes_of(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// rtl/ram_clear_ctrl.sv - post-reset zero-fill sequencer for ram_be_sync
// Drives clr_we/clr_addr onto the array write port and holds busy until the fill completes.
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int DEPTH          = 10,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             clr_we,
  output logic [DEPTH-1:0] clr_addr,
  output logic             busy
);

  // One extra counter bit keeps the last-address compare free of wrap ambiguity.
  localparam logic [DEPTH:0] LAST_ADDR = {1'b0, {DEPTH{1'b1}}};

  state_t           r_state;
  logic [DEPTH:0]   r_clr_cnt;
  logic             r_clr_we;
  logic             r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_INIT;
      r_clr_cnt <= '0;
      r_clr_we  <= 1'b0;
      r_busy    <= 1'b1;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_clr_cnt <= '0;
          if (CLEAR_ON_RESET != 0) begin
            r_state  <= ST_CLEAR;
            r_clr_we <= 1'b1;
          end else begin
            r_state <= ST_READY;
            r_busy  <= 1'b0;
          end
        end
        ST_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == LAST_ADDR) begin
            r_state  <= ST_READY;
            r_clr_we <= 1'b0;
            r_busy   <= 1'b0;
          end
        end
        ST_READY: begin
          r_state <= ST_READY;
        end
        default: begin
          r_state  <= ST_INIT;
          r_clr_we <= 1'b0;
          r_busy   <= 1'b1;
        end
      endcase
    end
  end

  assign clr_we   = r_clr_we;
  assign clr_addr = r_clr_cnt[DEPTH-1:0];
  assign busy     = r_busy;

endmodule

// File: rtl/ram_be_sync.sv
// rtl/ram_be_sync.sv - byte-enable synchronous RAM with registered read and zero-fill after reset
// Optional per-byte even parity storage and checking when RAM_PARITY_EN is defined.
module ram_be_sync
  import ram_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 10,
  parameter int READ_MODE      = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ram_ena,
  input  logic               wena,
  input  logic [WIDTH/8-1:0] byte_en,
  input  logic [DEPTH-1:0]   addr,
  input  logic [WIDTH-1:0]   data_in,
  output logic [WIDTH-1:0]   data_out,
  output logic               rd_valid,
  output logic               busy
`ifdef RAM_PARITY_EN
  ,
  output logic [WIDTH/8-1:0] parity_err
`endif
);

  localparam int NB = bytes_of(WIDTH);
`ifdef RAM_PARITY_EN
  localparam int SW = WIDTH + NB;
`else
  localparam int SW = WIDTH;
`endif

  logic [SW-1:0]    r_mem [2**DEPTH];

  logic             w_clr_we;
  logic [DEPTH-1:0] w_clr_addr;
  logic             w_busy;
  logic             w_acc;
  logic             w_we;
  logic [DEPTH-1:0] w_waddr;
  logic [SW-1:0]    w_old;
  logic [SW-1:0]    w_new;
  logic [SW-1:0]    w_wdata;
  logic             w_load;
  logic [SW-1:0]    w_load_word;

  ram_clear_ctrl #(
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr),
    .busy     (w_busy)
  );

  assign w_acc = ram_ena & ~w_busy;
  assign w_old = r_mem[addr];

  // Parity bits live above the data bits, one per lane, refreshed only for written lanes.
  always_comb begin
    w_new = w_old;
    for (int i = 0; i < NB; i++) begin
      if (byte_en[i]) begin
        w_new[8*i +: 8] = data_in[8*i +: 8];
`ifdef RAM_PARITY_EN
        w_new[WIDTH+i]  = ^data_in[8*i +: 8];
`endif
      end
    end
  end

  assign w_we    = w_clr_we | (w_acc & wena);
  assign w_waddr = w_clr_we ? w_clr_addr : addr;
  assign w_wdata = w_clr_we ? '0 : w_new;

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  always_comb begin
    w_load      = 1'b0;
    w_load_word = w_old;
    if (w_acc) begin
      if (!wena) begin
        w_load = 1'b1;
      end else if (READ_MODE == RM_WRITE_FIRST) begin
        w_load      = 1'b1;
        w_load_word = w_new;
      end else if (READ_MODE == RM_READ_FIRST) begin
        w_load = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= w_load;
      if (w_load) begin
        data_out <= w_load_word[WIDTH-1:0];
      end
    end
  end

`ifdef RAM_PARITY_EN
  logic [NB-1:0] w_perr;

  always_comb begin
    w_perr = '0;
    for (int i = 0; i < NB; i++) begin
      w_perr[i] = (^w_load_word[8*i +: 8]) ^ w_load_word[WIDTH+i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= '0;
    end else begin
      parity_err <= w_load ? w_perr : '0;
    end
  end
`endif

  assign busy = w_busy;

endmodule

// File: tb/tb_ram_be_sync.sv
// tb/tb_ram_be_sync.sv - self-checking bench for ram_be_sync, one instance per read-during-write mode
module tb_ram_be_sync;

  logic             clk;
  logic             rst_n;
  logic             ram_ena;
  logic             wena;
  logic [3:0]       byte_en;
  logic [3:0]       addr;
  logic [31:0]      data_in;
  logic [2:0][31:0] dout;
  logic [2:0]       rv;
  logic [2:0]       bz;
`ifdef RAM_PARITY_EN
  logic [2:0][3:0]  perr;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [16];
  logic [31:0] exp_do [3];
  logic        exp_v [3];

  for (genvar m = 0; m < 3; m++) begin : g_dut
    ram_be_sync #(
      .WIDTH          (32),
      .DEPTH          (4),
      .READ_MODE      (m),
      .CLEAR_ON_RESET (1)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ram_ena    (ram_ena),
      .wena       (wena),
      .byte_en    (byte_en),
      .addr       (addr),
      .data_in    (data_in),
      .data_out   (dout[m]),
      .rd_valid   (rv[m]),
      .busy       (bz[m])
`ifdef RAM_PARITY_EN
      ,
      .parity_err (perr[m])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: lane-wise merge, then pick what each read-during-write mode shows.
  task automatic acc(input logic en, input logic we, input logic [3:0] be,
                     input logic [3:0] a, input logic [31:0] d);
    logic [31:0] old_w;
    logic [31:0] new_w;
    ram_ena = en;
    wena    = we;
    byte_en = be;
    addr    = a;
    data_in = d;
    old_w = mem[a];
    new_w = old_w;
    for (int i = 0; i < 4; i++)
      if (be[i]) new_w = (new_w & ~(32'hFF << (8*i))) | (d & (32'hFF << (8*i)));
    if (!en) begin
      for (int m = 0; m < 3; m++) exp_v[m] = 1'b0;
    end else if (!we) begin
      for (int m = 0; m < 3; m++) begin
        exp_do[m] = old_w;
        exp_v[m]  = 1'b1;
      end
    end else begin
      mem[a]    = new_w;
      exp_do[0] = new_w;
      exp_v[0]  = 1'b1;
      exp_do[1] = old_w;
      exp_v[1]  = 1'b1;
      exp_v[2]  = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("data_out m%0d a%0d", m, a), dout[m], exp_do[m]);
      chk($sformatf("rd_valid m%0d a%0d", m, a), {31'd0, rv[m]}, {31'd0, exp_v[m]});
    end
  endtask

  task automatic wait_clear(input string tag);
    int cnt [3];
    logic any;
    for (int m = 0; m < 3; m++) cnt[m] = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      any = 1'b0;
      for (int m = 0; m < 3; m++)
        if (bz[m]) begin
          cnt[m]++;
          any = 1'b1;
        end
      if (!any) break;
    end
    for (int m = 0; m < 3; m++) chk($sformatf("%s busy cycles m%0d", tag, m), cnt[m], 32'd16);
  endtask

  task automatic chk_reset(input string tag);
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("%s data_out m%0d", tag, m), dout[m], 32'd0);
      chk($sformatf("%s rd_valid m%0d", tag, m), {31'd0, rv[m]}, 32'd0);
      chk($sformatf("%s busy m%0d", tag, m), {31'd0, bz[m]}, 32'd1);
      exp_do[m] = '0;
      exp_v[m]  = 1'b0;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    ram_ena = 1'b0;
    wena    = 1'b0;
    byte_en = '0;
    addr    = '0;
    data_in = '0;
    for (int a = 0; a < 16; a++) mem[a] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");

    // Lockout: this write is presented for the whole clear and must be dropped.
    ram_ena = 1'b1;
    wena    = 1'b1;
    byte_en = 4'hF;
    addr    = 4'd2;
    data_in = 32'hDEADBEEF;
    rst_n   = 1'b1;
    wait_clear("clear");
    ram_ena = 1'b0;

    for (int a = 0; a < 16; a++) acc(1'b1, 1'b0, 4'h0, 4'(a), 32'h0);
    chk("lockout addr2", dout[0], 32'd0);

    acc(1'b1, 1'b1, 4'b1111, 4'd3, 32'hAABBCCDD);
    acc(1'b1, 1'b1, 4'b0101, 4'd3, 32'h11223344);
    acc(1'b1, 1'b0, 4'b0000, 4'd3, 32'h0);
    chk("be merge", dout[0], 32'hAA22CC44);

    acc(1'b1, 1'b1, 4'b1111, 4'd5, 32'h12345678);
    acc(1'b1, 1'b1, 4'b0011, 4'd5, 32'hFFFFFFFF);
    chk("rdw write_first", dout[0], 32'h1234FFFF);
    chk("rdw read_first", dout[1], 32'h12345678);
    chk("rdw no_change", dout[2], 32'hAA22CC44);
    chk("rdw no_change valid", {31'd0, rv[2]}, 32'd0);

    acc(1'b1, 1'b1, 4'b0000, 4'd5, 32'h0BADF00D);
    acc(1'b0, 1'b0, 4'b0000, 4'd5, 32'h0);
    acc(1'b1, 1'b0, 4'b0000, 4'd15, 32'h0);
    acc(1'b1, 1'b1, 4'b1000, 4'd15, 32'hC3000000);

    for (int k = 0; k < 300; k++)
      acc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom),
          4'($urandom), $urandom);

`ifdef RAM_PARITY_EN
    acc(1'b1, 1'b1, 4'b1111, 4'd7, 32'h0F0F0F0F);
    g_dut[0].u_dut.r_mem[7][9] = ~g_dut[0].u_dut.r_mem[7][9];
    g_dut[1].u_dut.r_mem[7][9] = ~g_dut[1].u_dut.r_mem[7][9];
    g_dut[2].u_dut.r_mem[7][9] = ~g_dut[2].u_dut.r_mem[7][9];
    mem[7] = mem[7] ^ 32'h0000_0200;
    acc(1'b1, 1'b0, 4'b0000, 4'd7, 32'h0);
    for (int m = 0; m < 3; m++) chk($sformatf("parity flip m%0d", m), {28'd0, perr[m]}, 32'h2);
    acc(1'b1, 1'b0, 4'b0000, 4'd3, 32'h0);
    for (int m = 0; m < 3; m++) chk($sformatf("parity clean m%0d", m), {28'd0, perr[m]}, 32'h0);
`endif

    // Asynchronous reset from READY, away from any clock edge.
    @(posedge clk);
    #2;
    ram_ena = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk_reset("async reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset("mid-clear reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_clear("reclear");
    for (int a = 0; a < 16; a++) mem[a] = '0;
    for (int a = 0; a < 16; a++) acc(1'b1, 1'b0, 4'h0, 4'(a), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
